// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx : 8N1 UART receiver (LSB first, idle-high line).
//
// SI is brought into the CLK domain through a two-flop synchroniser (rx_s).
// The start bit is confirmed at half a bit time, data and stop bits are
// evaluated at mid-bit, and every good byte is presented on Data with a
// one-cycle Valid strobe. A low stop bit raises a one-cycle Frame_Err pulse,
// after which the receiver waits for the line to return high before it will
// look for another start bit.
//
// Optional build macro: UART_RX_MAJORITY_EN
//   defined   : each bit is the 2-of-3 majority of rx_s at the evaluation
//               cycle and the two cycles before it (single-cycle glitch
//               rejection). Evaluation timing is unchanged.
//   undefined : each bit is rx_s in the evaluation cycle.
//
// CLKS_PER_BIT (= CLK_FREQ / BAUD_RATE) must be at least 8.
// ---------------------------------------------------------------------------
`default_nettype none

module uart_rx #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 115200
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SI,
  output logic [7:0] Data,
  output logic       Valid,
  output logic       Frame_Err,
  output logic       Busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } state_t;

  // 2-of-3 majority vote used for bit evaluation when glitch rejection is on
  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  // Registers
  state_t            state_r;
  logic [1:0]        sync_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [2:0]        idx_r;
  logic [7:0]        shift_r;
  logic [7:0]        data_r;
  logic              valid_r;
  logic              ferr_r;
  logic              busy_r;

  // Next-state / combinational signals
  state_t            next_state_s;
  logic [CNT_W-1:0]  cnt_nxt_s;
  logic [2:0]        idx_nxt_s;
  logic [7:0]        shift_nxt_s;
  logic [7:0]        data_nxt_s;
  logic              valid_nxt_s;
  logic              ferr_nxt_s;
  logic              rx_s;
  logic              bit_s;
  logic              bit_done_s;

  assign rx_s = sync_r[1];

  // Two-flop synchroniser for the asynchronous serial input; idles high
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], SI};
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // History of the two rx_s samples preceding the current cycle; together
  // with rx_s it forms the 3-sample voting window.
  logic [1:0] hist_r;
  logic [2:0] win_s;

  // Shift rx_s into the voting history every cycle
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hist_r <= 2'b11;
    end else begin
      hist_r <= {hist_r[0], rx_s};
    end
  end

  assign win_s = {hist_r, rx_s};
  assign bit_s = maj3(win_s);
`else
  assign bit_s = rx_s;
`endif

  // A data bit finishes at the end of its bit period; the counter restarts
  assign bit_done_s = (state_r == ST_DATA) && (cnt_r == BIT_LAST);

  // Next-state logic: framing FSM, bit capture and output pulse generation
  always_comb begin
    next_state_s = state_r;
    idx_nxt_s    = idx_r;
    shift_nxt_s  = shift_r;
    data_nxt_s   = data_r;
    valid_nxt_s  = 1'b0;
    ferr_nxt_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (rx_s == 1'b0) begin
          next_state_s = ST_START;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (cnt_r == HALF_LAST) begin
          if (bit_s == 1'b0) begin
            next_state_s = ST_DATA;
            idx_nxt_s    = 3'd0;
          end else begin
            // Line went back high before mid start bit: false start
            next_state_s = ST_IDLE;
          end
        end else begin
          next_state_s = ST_START;
        end
      end
      ST_DATA: begin
        if (cnt_r == BIT_LAST) begin
          shift_nxt_s[idx_r] = bit_s;
          if (idx_r == 3'd7) begin
            next_state_s = ST_STOP;
            idx_nxt_s    = 3'd0;
          end else begin
            next_state_s = ST_DATA;
            idx_nxt_s    = idx_r + 3'd1;
          end
        end else begin
          next_state_s = ST_DATA;
        end
      end
      ST_STOP: begin
        if (cnt_r == BIT_LAST) begin
          if (bit_s == 1'b1) begin
            data_nxt_s   = shift_r;
            valid_nxt_s  = 1'b1;
            next_state_s = ST_IDLE;
          end else begin
            // Data is left untouched; hold off until the line recovers
            ferr_nxt_s   = 1'b1;
            next_state_s = ST_WAIT_HIGH;
          end
        end else begin
          next_state_s = ST_STOP;
        end
      end
      ST_WAIT_HIGH: begin
        if (rx_s == 1'b1) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_WAIT_HIGH;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
        idx_nxt_s    = 3'd0;
      end
    endcase
  end

  // Clock counter: cleared on every state change and at each data bit
  // boundary; parked at zero while idle or waiting for the line to go high
  always_comb begin
    cnt_nxt_s = CNT_ZERO;
    if ((next_state_s != state_r) || bit_done_s ||
        (state_r == ST_IDLE) || (state_r == ST_WAIT_HIGH)) begin
      cnt_nxt_s = CNT_ZERO;
    end else begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end
  end

  // State, counters, shift register and registered outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
      idx_r   <= 3'd0;
      shift_r <= 8'h00;
      data_r  <= 8'h00;
      valid_r <= 1'b0;
      ferr_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      cnt_r   <= cnt_nxt_s;
      idx_r   <= idx_nxt_s;
      shift_r <= shift_nxt_s;
      data_r  <= data_nxt_s;
      valid_r <= valid_nxt_s;
      ferr_r  <= ferr_nxt_s;
      busy_r  <= (next_state_s != ST_IDLE);
    end
  end

  assign Data      = data_r;
  assign Valid     = valid_r;
  assign Frame_Err = ferr_r;
  assign Busy      = busy_r;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx : self-checking bench for uart_rx.
// Small bit period (32 clocks) so frames are short. A table of frames is
// applied first, then hand-written sequences cover false start, framing
// error with a held-low line, and reset in the middle of a frame.
// Expected values for the glitched frame depend on UART_RX_MAJORITY_EN.
// ---------------------------------------------------------------------------
module tb_uart_rx;

  localparam int CLK_FREQ = 3200;
  localparam int BAUD     = 100;
  localparam int CPB      = CLK_FREQ / BAUD;  // 32
  localparam int HALF     = CPB / 2;          // 16
  localparam int NO_ABORT = 99;

  logic       CLK;
  logic       RST;
  logic       SI;
  logic [7:0] Data;
  logic       Valid;
  logic       Frame_Err;
  logic       Busy;

  int n_pass;
  int n_total;

  int valid_cnt;
  int ferr_cnt;
  int both_cnt;

  uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .SI        (SI),
    .Data      (Data),
    .Valid     (Valid),
    .Frame_Err (Frame_Err),
    .Busy      (Busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Count output pulse cycles away from the active edge
  always @(negedge CLK) begin
    if (Valid === 1'b1) valid_cnt = valid_cnt + 1;
    if (Frame_Err === 1'b1) ferr_cnt = ferr_cnt + 1;
    if ((Valid === 1'b1) && (Frame_Err === 1'b1)) both_cnt = both_cnt + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_total = n_total + 1;
    if (act == exp) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one frame cycle by cycle. Optional 1-clock inverted glitch at the
  // mid-bit cycle of every data bit, optional reset at the start of bit
  // abort_bit (bit 0 = start bit). Counts data-bit cycles with Busy low.
  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input bit glitch, input int abort_bit,
                            output int busy_lows);
    logic [9:0] bits;
    bits      = {stop, d, 1'b0};
    busy_lows = 0;
    for (int n = 0; n < 10; n++) begin
      for (int c = 0; c < CPB; c++) begin
        @(negedge CLK);
        if ((n >= 1) && (n <= 8) && (Busy !== 1'b1)) busy_lows = busy_lows + 1;
        if ((n == abort_bit) && (c == 0)) begin
          RST = 1'b1;
          #1;
          chk("abort_rst_data",  int'(Data),      0);
          chk("abort_rst_valid", int'(Valid),     0);
          chk("abort_rst_ferr",  int'(Frame_Err), 0);
          chk("abort_rst_busy",  int'(Busy),      0);
          @(negedge CLK);
          RST = 1'b0;
          SI  = 1'b1;
          return;
        end
        if (glitch && (n >= 1) && (n <= 8) && (c == HALF)) SI = ~bits[n];
        else SI = bits[n];
      end
    end
  endtask

  typedef struct {
    logic [7:0] d;
    bit         glitch;
    int         gap;
    logic [7:0] exp_d;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    int f0;
    int bl;
    logic [7:0] exp_last;
    logic [7:0] glitch_exp;

    n_pass    = 0;
    n_total   = 0;
    valid_cnt = 0;
    ferr_cnt  = 0;
    both_cnt  = 0;

`ifdef UART_RX_MAJORITY_EN
    glitch_exp = 8'hF0;
`else
    glitch_exp = 8'h0F;
`endif
    // Loopback byte, then three back-to-back frames, then glitched frame
    vecs[0] = '{d: 8'hA5, glitch: 1'b0, gap: 40, exp_d: 8'hA5};
    vecs[1] = '{d: 8'h00, glitch: 1'b0, gap: 0,  exp_d: 8'h00};
    vecs[2] = '{d: 8'hFF, glitch: 1'b0, gap: 0,  exp_d: 8'hFF};
    vecs[3] = '{d: 8'h3C, glitch: 1'b0, gap: 40, exp_d: 8'h3C};
    vecs[4] = '{d: 8'hF0, glitch: 1'b1, gap: 40, exp_d: glitch_exp};

    // Reset state
    RST = 1'b1;
    SI  = 1'b1;
    #2;
    chk("reset_data",  int'(Data),      0);
    chk("reset_valid", int'(Valid),     0);
    chk("reset_ferr",  int'(Frame_Err), 0);
    chk("reset_busy",  int'(Busy),      0);
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    repeat (10) @(negedge CLK);

    // Table-driven frames
    for (int i = 0; i < 5; i++) begin
      v0 = valid_cnt;
      f0 = ferr_cnt;
      send_frame(vecs[i].d, 1'b1, vecs[i].glitch, NO_ABORT, bl);
      repeat (vecs[i].gap) @(negedge CLK);
      chk($sformatf("vec%0d_valid_pulses", i), valid_cnt - v0, 1);
      chk($sformatf("vec%0d_ferr_pulses", i), ferr_cnt - f0, 0);
      chk($sformatf("vec%0d_data", i), int'(Data), int'(vecs[i].exp_d));
      chk($sformatf("vec%0d_busy_in_frame", i), bl, 0);
      if (vecs[i].gap > 0) chk($sformatf("vec%0d_busy_idle", i), int'(Busy), 0);
    end
    exp_last = vecs[4].exp_d;

    // False start: line low for fewer than HALF clocks
    v0 = valid_cnt;
    f0 = ferr_cnt;
    @(negedge CLK);
    SI = 1'b0;
    repeat (HALF - 6) @(negedge CLK);
    SI = 1'b1;
    repeat (3) @(negedge CLK);
    chk("false_start_busy_hi", int'(Busy), 1);
    repeat (2 * CPB) @(negedge CLK);
    chk("false_start_busy_lo", int'(Busy), 0);
    chk("false_start_valid", valid_cnt - v0, 0);
    chk("false_start_ferr", ferr_cnt - f0, 0);
    chk("false_start_data", int'(Data), int'(exp_last));

    // Framing error, line held low 3 more bit times
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send_frame(8'h55, 1'b0, 1'b0, NO_ABORT, bl);
    repeat (3 * CPB) @(negedge CLK);
    chk("ferr_busy_held", int'(Busy), 1);
    SI = 1'b1;
    repeat (6) @(negedge CLK);
    chk("ferr_busy_released", int'(Busy), 0);
    chk("ferr_pulses", ferr_cnt - f0, 1);
    chk("ferr_valid", valid_cnt - v0, 0);
    chk("ferr_data_kept", int'(Data), int'(exp_last));
    repeat (10) @(negedge CLK);
    v0 = valid_cnt;
    send_frame(8'h12, 1'b1, 1'b0, NO_ABORT, bl);
    repeat (40) @(negedge CLK);
    chk("after_ferr_valid", valid_cnt - v0, 1);
    chk("after_ferr_data", int'(Data), 32'h12);

    // Reset during data bit 4 of 0x81
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send_frame(8'h81, 1'b1, 1'b0, 5, bl);
    repeat (3 * CPB) @(negedge CLK);
    chk("abort_no_valid", valid_cnt - v0, 0);
    chk("abort_no_ferr", ferr_cnt - f0, 0);
    chk("abort_data_zero", int'(Data), 0);
    chk("abort_busy_idle", int'(Busy), 0);
    v0 = valid_cnt;
    send_frame(8'h7E, 1'b1, 1'b0, NO_ABORT, bl);
    repeat (40) @(negedge CLK);
    chk("after_abort_valid", valid_cnt - v0, 1);
    chk("after_abort_data", int'(Data), 32'h7E);

    chk("valid_ferr_overlap", both_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver; downstream peer of the uart_tx stage, consuming its serial output SO.
- Frame format: 8N1, LSB first, idle-high line.
- Synchronises the serial input, checks the start bit, samples each bit at mid-bit, checks the stop bit.
- Presents each received byte with a one-cycle Valid strobe.
- Feeds the RX-side byte consumer (command decoder or FIFO) in the same clock domain as the transmitter.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD_RATE, 115200, serial bit rate. Local CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (434 at defaults); HALF_BIT = CLKS_PER_BIT/2 (integer division). CLKS_PER_BIT must be >= 8.

Ports:
- CLK  input  1  system clock; all logic on the rising edge.
- RST  input  1  asynchronous, active-high reset.
- SI  input  1  serial data in, asynchronous to CLK, idle high.
- Data  output  8  last correctly framed byte; holds until the next good frame.
- Valid  output  1  one-cycle pulse: Data updated this cycle.
- Frame_Err  output  1  one-cycle pulse: stop bit sampled low.
- Busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async, RST=1):
  - Data=0, Valid=0, Frame_Err=0, Busy=0; state=IDLE.
  - Synchroniser flops=1; bit counter and clock counter=0.
  - Reset mid-frame aborts the frame with no Valid or Frame_Err.
  - After release, the FSM waits in IDLE for a fresh falling edge.
- Synchroniser: 2 flops on SI, giving rx_s (2-cycle lag). The FSM uses only rx_s.
- Clock counter: width $clog2(CLKS_PER_BIT); cleared on every state change.
- IDLE:
  - Busy=0.
  - rx_s==0 -> START, counter=0.
- START:
  - At counter==HALF_BIT-1, evaluate the bit.
  - Bit==0 -> DATA, counter=0, bit_idx=0.
  - Bit==1 -> false start; return to IDLE with no pulse.
- DATA:
  - At counter==CLKS_PER_BIT-1, evaluate the bit and store it in shift[bit_idx] (LSB first); counter=0.
  - bit_idx 0..7; after bit 7 -> STOP, bit_idx=0.
- STOP:
  - At counter==CLKS_PER_BIT-1, evaluate the bit.
  - Bit==1: Data<=shift and Valid=1 for exactly one cycle -> IDLE.
  - Bit==0: Frame_Err=1 for one cycle, Data unchanged -> WAIT_HIGH.
- WAIT_HIGH:
  - Busy=1; stay until rx_s==1, then -> IDLE.
  - Prevents a break or stuck-low line from retriggering starts.
- Latency: Valid rises about 9.5 bit times plus 2-3 clocks after the SI falling edge (mid-stop bit). The FSM is back in IDLE before the stop bit ends, so back-to-back frames with 1 stop bit are received without loss.
- Valid and Frame_Err are never high in the same cycle. Both are registered outputs.
- Simultaneous events: RST overrides everything. An SI edge during STOP evaluation is irrelevant; only the evaluation sample counts.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined:
  - Each bit evaluation is the 2-of-3 majority of rx_s sampled at evaluation point -2, -1 and the evaluation cycle itself.
  - Applies to START, DATA and STOP.
  - Rejects single-cycle glitches at the sample point.
  - Adds a 3-bit sample register.
- Undefined: the bit evaluation is rx_s in the evaluation cycle only; no extra registers.
- Evaluation timing and latency are identical in both builds.

Test Plan:
- Loopback from uart_tx, Send with Data=0xA5 -> exactly one Valid pulse, Data=0xA5, Frame_Err never high; Busy high from start detect to return to IDLE.
- Back-to-back frames 0x00, 0xFF, 0x3C, stop bit 1 bit long -> three Valid pulses in order, Data=0x00, then 0xFF, then 0x3C; no frame lost.
- SI low for 100 clocks then high -> return to IDLE at HALF_BIT; no Valid, no Frame_Err; Data keeps its previous value.
- Frame 0x55 with stop bit driven 0, SI held low 3 more bit times, then high -> one Frame_Err pulse, no Valid, Data unchanged. Busy stays high until rx_s returns high; the next frame 0x12 is received correctly.
- RST pulsed during data bit 4 of frame 0x81 -> all outputs go to reset values immediately; no pulse for the aborted frame. The following frame 0x7E gives Valid with Data=0x7E.
- With UART_RX_MAJORITY_EN, frame 0xF0 with a 1-clock inverted glitch on every data bit's evaluation cycle -> Data=0xF0. Same stimulus without the macro -> Data=0x0F.
